// File: rtl/contador_updown_param.sv
// -----------------------------------------------------------------------------
// contador_updown_param
//
// Parametrised up/down counter with a runtime upper limit, a direction select
// and a wrap/saturate mode. A clock-enable prescaler sets the count rate. A
// synchronous preset and a synchronous load are provided. This block replaces
// the 3-bit saturating down counter: with up=0, wrap_en=0 and limit=7 it
// behaves exactly like that older block.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   DIV      prescaler ratio; the counter steps once every DIV enabled clocks
//   RST_VAL  value of q after reset (<= 2^WIDTH-1)
//
// Ports
//   clk       in   rising-edge clock
//   clr_n     in   asynchronous active-low reset
//   en        in   count enable; freezes the prescaler and the counter when low
//   up        in   1 = increment, 0 = decrement
//   wrap_en   in   1 = wrap at the bounds, 0 = saturate at the bounds
//   limit     in   upper bound of the count range [0, limit]
//   prst      in   synchronous preset, q <= limit (highest synchronous priority)
//   load      in   synchronous load, q <= load_val
//   load_val  in   value for load (may lie above limit)
//   q         out  current count
//   step      out  combinational prescaler tick
//   at_end    out  combinational end-of-range flag for the current direction
//   wrap      out  registered one-cycle pulse following a wrap event
// -----------------------------------------------------------------------------
module contador_updown_param #(
  parameter int WIDTH   = 3,
  parameter int DIV     = 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] limit,
  input  logic             prst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             at_end,
  output logic             wrap
);

  // The prescaler always has at least one bit so DIV=1 still yields a legal
  // vector. With DIV=1 the prescaler sits at 0, and step then equals en.
  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]   PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] Q_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_RST   = WIDTH'(RST_VAL);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             q_is_zero;
  logic             q_at_top;

  assign q_is_zero = (q == Q_ZERO);
  // Use >= rather than == so that a value loaded above limit also counts as
  // being at the top of the range.
  assign q_at_top  = (q >= limit);

  // Prescaler tick and end-of-range flag, both combinational.
  assign step   = en & (pre == PRE_LAST);
  assign at_end = (up & q_at_top) | (~up & q_is_zero);

  // Next-state function. Priority is prst > load > stepped count > hold.
  always_comb begin
    pre_next  = pre;
    q_next    = q;
    wrap_next = 1'b0;

    if (prst) begin
      q_next   = limit;
      pre_next = PRE_ZERO;
    end else if (load) begin
      // Values above limit are accepted; a later down step walks back
      // into range, and an up step sees q >= limit.
      q_next   = load_val;
      pre_next = PRE_ZERO;
    end else begin
      if (en) begin
        if (pre == PRE_LAST) begin
          pre_next = PRE_ZERO;
        end else begin
          pre_next = pre + PRE_ONE;
        end
      end else begin
        pre_next = pre;
      end

      if (step) begin
        if (up) begin
          if (!q_at_top) begin
            q_next = q + Q_ONE;
          end else if (wrap_en) begin
            q_next    = Q_ZERO;
            wrap_next = 1'b1;
          end else begin
            q_next = q;
          end
        end else begin
          if (!q_is_zero) begin
            q_next = q - Q_ONE;
          end else if (wrap_en) begin
            // With limit=0 this reloads 0 but still reports the wrap.
            q_next    = limit;
            wrap_next = 1'b1;
          end else begin
            q_next = q;
          end
        end
      end else begin
        q_next = q;
      end
    end
  end

  // State registers. Reset discards any partial prescale count.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q    <= Q_RST;
      pre  <= PRE_ZERO;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      pre  <= pre_next;
      wrap <= wrap_next;
    end
  end

endmodule
